axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Two-requester AXI-Lite read-channel arbiter that shares the single memory read port between the IFU (instruction fetch) and the LSU (loads).
- Sits between the IFU and LSU master ports and the memory/xbar slave.
- Allows one outstanding transaction in total. The grant is held from AR acceptance until the R handshake completes.
- Uses round-robin priority when both requesters are valid in the same cycle.

Parameters:
ADDR_W, 32, AR address width
DATA_W, 32, R data width

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  reset; asynchronous, active-low
ifu_ar_valid_i  in  1  IFU read request
ifu_ar_addr_i  in  ADDR_W  IFU read address
ifu_ar_ready_o  out  1  AR accepted for IFU
ifu_r_valid_o  out  1  read data valid to IFU
ifu_r_data_o  out  DATA_W  read data to IFU
ifu_r_resp_o  out  2  read response to IFU
ifu_r_ready_i  in  1  IFU accepts data
lsu_ar_valid_i  in  1  LSU read request
lsu_ar_addr_i  in  ADDR_W  LSU read address
lsu_ar_ready_o  out  1  AR accepted for LSU
lsu_r_valid_o  out  1  read data valid to LSU
lsu_r_data_o  out  DATA_W  read data to LSU
lsu_r_resp_o  out  2  read response to LSU
lsu_r_ready_i  in  1  LSU accepts data
mst_ar_valid_o  out  1  request to slave
mst_ar_addr_o  out  ADDR_W  address to slave
mst_ar_ready_i  in  1  slave accepts AR
mst_r_valid_i  in  1  slave data valid
mst_r_data_i  in  DATA_W  slave data
mst_r_resp_i  in  2  slave response
mst_r_ready_o  out  1  ready to slave

Behaviour:
- States (one-hot): IDLE, ADDR, DATA.
- Registers: state, grant (0=IFU, 1=LSU), last (most recently served requester).
- Reset (rst_i=0, asynchronous): state=IDLE, grant=0, last=1, so the IFU wins the first tie. All outputs are 0, and data/resp outputs are 0.
- IDLE:
  - If only one requester is valid, grant goes to that requester.
  - If both are valid, grant goes to the requester that is not `last`.
  - If any requester is valid, next state is ADDR.
  - mst_ar_valid_o=0 and mst_r_ready_o=0 in IDLE.
  - Minimum arbitration latency is 1 cycle: the request is seen in IDLE and forwarded in ADDR.
- ADDR:
  - Drive mst_ar_valid_o and mst_ar_addr_o combinationally from the granted requester's ar_valid and ar_addr.
  - The granted requester's ar_ready_o equals mst_ar_ready_i. The other requester's ar_ready_o=0.
  - On mst_ar_valid_o & mst_ar_ready_i, go to DATA.
  - If the granted requester drops ar_valid before the handshake (protocol violation), the grant is held and the block stays in ADDR.
- DATA:
  - mst_r_ready_o equals the granted requester's r_ready_i.
  - The granted requester's r_valid_o equals mst_r_valid_i, and its r_data_o/r_resp_o equal the slave values. The other requester sees r_valid_o=0.
  - On mst_r_valid_i & mst_r_ready_o: last<=grant, go to IDLE.
  - Back-to-back throughput is one transaction per 3 cycles minimum.
- Non-granted requester: ar_ready_o stays 0. Its valid and address must be held per AXI rules. The arbiter never drops a pending request.
- Spurious mst_r_valid_i in IDLE or ADDR: ignored, mst_r_ready_o=0, nothing forwarded.
- mst_r_resp_i is passed through unchanged. A SLVERR/DECERR response completes the transaction normally.
- Reset asserted mid-transaction: immediately returns to IDLE with all handshakes low. Any in-flight slave response is discarded.
- No combinational path from requester valid to mst_ar_valid_o in IDLE. The grant is always registered first.

Decomposition:
- Shared package: state encodings (IDLE/ADDR/DATA), requester IDs (REQ_IFU=0, REQ_LSU=1), AXI resp codes (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11).
- Bus widths use the existing axi addr/data bus macros.
- One sub-module is natural: rr_arb2, a combinational 2-way round-robin pick from (req[1:0], last), returning grant.

Test Plan:
- Hold rst_i=0 for 3 cycles, then release -> all outputs 0, state IDLE; first cycle after release with no requests -> mst_ar_valid_o=0.
- Single IFU read: ifu_ar_valid_i=1, addr=0x8000_0000; slave ar_ready on the first ADDR cycle; r_data=0x0000_0413, resp=OKAY -> ifu_r_valid_o=1 with 0x0000_0413; lsu_r_valid_o stays 0; returns to IDLE after the R handshake.
- Simultaneous IFU (0x8000_0004) and LSU (0x8000_1000) requests after reset -> IFU served first; LSU served next; repeating with both valid alternates IFU/LSU strictly.
- Slave delays ar_ready 4 cycles and r_valid 5 cycles; requester holds r_ready=0 for 2 cycles -> mst_ar_valid_o and address stable throughout; data is held and forwarded only on the handshake; no grant change.
- Slave returns resp=DECERR for an LSU read at 0x0000_0000 -> lsu_r_resp_o=2'b11; arbiter returns to IDLE and serves the next IFU request normally.
- Assert rst_i low during DATA with mst_r_valid_i=1 -> outputs go 0 asynchronously; no r_valid is forwarded; after release, the IFU wins the first tie.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types for the IFU/LSU read-channel arbiter: FSM encoding, requester IDs
// and AXI response codes.
package axi_rd_arbiter_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_ADDR = 3'b010,
        ST_DATA = 3'b100
    } state_e;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    function automatic req_id_e other_req(input req_id_e id);
        return (id == REQ_IFU) ? REQ_LSU : REQ_IFU;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: a lone requester wins outright, a tie
// goes to whichever requester was not served last.
module axi_rd_arbiter_rr_arb2
    import axi_rd_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  req_id_e    last_i,
    output req_id_e    grant_o
);

    always_comb begin
        grant_o = REQ_IFU;
        unique case (req_i)
            2'b01:   grant_o = REQ_IFU;
            2'b10:   grant_o = REQ_LSU;
            2'b11:   grant_o = other_req(last_i);
            default: grant_o = REQ_IFU;
        endcase
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI-Lite read port between IFU and LSU with a single outstanding
// transaction; the grant is registered in IDLE and held until the R handshake.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              ifu_ar_valid_i,
    input  logic [ADDR_W-1:0] ifu_ar_addr_i,
    output logic              ifu_ar_ready_o,
    output logic              ifu_r_valid_o,
    output logic [DATA_W-1:0] ifu_r_data_o,
    output logic [1:0]        ifu_r_resp_o,
    input  logic              ifu_r_ready_i,

    input  logic              lsu_ar_valid_i,
    input  logic [ADDR_W-1:0] lsu_ar_addr_i,
    output logic              lsu_ar_ready_o,
    output logic              lsu_r_valid_o,
    output logic [DATA_W-1:0] lsu_r_data_o,
    output logic [1:0]        lsu_r_resp_o,
    input  logic              lsu_r_ready_i,

    output logic              mst_ar_valid_o,
    output logic [ADDR_W-1:0] mst_ar_addr_o,
    input  logic              mst_ar_ready_i,
    input  logic              mst_r_valid_i,
    input  logic [DATA_W-1:0] mst_r_data_i,
    input  logic [1:0]        mst_r_resp_i,
    output logic              mst_r_ready_o
);

    state_e  state_q, state_d;
    req_id_e grant_q, grant_d;
    req_id_e last_q,  last_d;
    req_id_e rr_grant;

    logic [1:0] req;
    logic       in_addr;
    logic       in_data;
    logic       gnt_ifu;
    logic       ar_fire;
    logic       r_fire;

    assign req     = {lsu_ar_valid_i, ifu_ar_valid_i};
    assign in_addr = (state_q == ST_ADDR);
    assign in_data = (state_q == ST_DATA);
    assign gnt_ifu = (grant_q == REQ_IFU);
    assign ar_fire = mst_ar_valid_o & mst_ar_ready_i;
    assign r_fire  = mst_r_valid_i & mst_r_ready_o;

    axi_rd_arbiter_rr_arb2 u_rr_arb2 (
        .req_i   (req),
        .last_i  (last_q),
        .grant_o (rr_grant)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d = rr_grant;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // A requester that drops valid early simply stalls here; the grant never moves.
                if (ar_fire) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_fire) begin
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are gated by the registered state, so nothing reaches the slave from IDLE.
    always_comb begin
        mst_ar_valid_o = 1'b0;
        mst_ar_addr_o  = '0;
        mst_r_ready_o  = 1'b0;
        ifu_ar_ready_o = 1'b0;
        lsu_ar_ready_o = 1'b0;
        ifu_r_valid_o  = 1'b0;
        ifu_r_data_o   = '0;
        ifu_r_resp_o   = 2'b00;
        lsu_r_valid_o  = 1'b0;
        lsu_r_data_o   = '0;
        lsu_r_resp_o   = 2'b00;

        if (in_addr) begin
            if (gnt_ifu) begin
                mst_ar_valid_o = ifu_ar_valid_i;
                mst_ar_addr_o  = ifu_ar_addr_i;
                ifu_ar_ready_o = mst_ar_ready_i;
            end else begin
                mst_ar_valid_o = lsu_ar_valid_i;
                mst_ar_addr_o  = lsu_ar_addr_i;
                lsu_ar_ready_o = mst_ar_ready_i;
            end
        end

        if (in_data) begin
            if (gnt_ifu) begin
                mst_r_ready_o = ifu_r_ready_i;
                ifu_r_valid_o = mst_r_valid_i;
                if (mst_r_valid_i) begin
                    ifu_r_data_o = mst_r_data_i;
                    ifu_r_resp_o = mst_r_resp_i;
                end
            end else begin
                mst_r_ready_o = lsu_r_ready_i;
                lsu_r_valid_o = mst_r_valid_i;
                if (mst_r_valid_i) begin
                    lsu_r_data_o = mst_r_data_i;
                    lsu_r_resp_o = mst_r_resp_i;
                end
            end
        end
    end

    // last resets to LSU so the IFU wins the first tie.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= REQ_IFU;
            last_q  <= REQ_LSU;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: a table of single read transactions with
// hand-computed winners, plus hand-written reset sequences.
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ifu_ar_valid_i, lsu_ar_valid_i;
    logic [31:0] ifu_ar_addr_i, lsu_ar_addr_i;
    logic        ifu_ar_ready_o, lsu_ar_ready_o;
    logic        ifu_r_valid_o, lsu_r_valid_o;
    logic [31:0] ifu_r_data_o, lsu_r_data_o;
    logic [1:0]  ifu_r_resp_o, lsu_r_resp_o;
    logic        ifu_r_ready_i, lsu_r_ready_i;
    logic        mst_ar_valid_o;
    logic [31:0] mst_ar_addr_o;
    logic        mst_ar_ready_i;
    logic        mst_r_valid_i;
    logic [31:0] mst_r_data_i;
    logic [1:0]  mst_r_resp_i;
    logic        mst_r_ready_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic        do_reset;
        logic        ifu_v;
        logic [31:0] ifu_addr;
        logic        lsu_v;
        logic [31:0] lsu_addr;
        logic        exp_grant;
        logic [31:0] exp_addr;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          ar_delay;
        int          r_delay;
        int          rdy_delay;
    } vec_t;

    vec_t vecs[7];

    axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ifu_ar_valid_i (ifu_ar_valid_i),
        .ifu_ar_addr_i  (ifu_ar_addr_i),
        .ifu_ar_ready_o (ifu_ar_ready_o),
        .ifu_r_valid_o  (ifu_r_valid_o),
        .ifu_r_data_o   (ifu_r_data_o),
        .ifu_r_resp_o   (ifu_r_resp_o),
        .ifu_r_ready_i  (ifu_r_ready_i),
        .lsu_ar_valid_i (lsu_ar_valid_i),
        .lsu_ar_addr_i  (lsu_ar_addr_i),
        .lsu_ar_ready_o (lsu_ar_ready_o),
        .lsu_r_valid_o  (lsu_r_valid_o),
        .lsu_r_data_o   (lsu_r_data_o),
        .lsu_r_resp_o   (lsu_r_resp_o),
        .lsu_r_ready_i  (lsu_r_ready_i),
        .mst_ar_valid_o (mst_ar_valid_o),
        .mst_ar_addr_o  (mst_ar_addr_o),
        .mst_ar_ready_i (mst_ar_ready_i),
        .mst_r_valid_i  (mst_r_valid_i),
        .mst_r_data_i   (mst_r_data_i),
        .mst_r_resp_i   (mst_r_resp_i),
        .mst_r_ready_o  (mst_r_ready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        ifu_ar_valid_i = 1'b0;
        ifu_ar_addr_i  = '0;
        lsu_ar_valid_i = 1'b0;
        lsu_ar_addr_i  = '0;
        ifu_r_ready_i  = 1'b0;
        lsu_r_ready_i  = 1'b0;
        mst_ar_ready_i = 1'b0;
        mst_r_valid_i  = 1'b0;
        mst_r_data_i   = '0;
        mst_r_resp_i   = 2'b00;
    endtask

    // Reset is held three cycles with slave handshakes wiggling to prove nothing leaks out.
    task automatic apply_reset();
        clear_inputs();
        rst_i          = 1'b0;
        mst_ar_ready_i = 1'b1;
        mst_r_valid_i  = 1'b1;
        mst_r_data_i   = 32'hCAFE_F00D;
        ifu_r_ready_i  = 1'b1;
        lsu_r_ready_i  = 1'b1;
        repeat (3) tick();
        check_output("rst_handshakes",
                     {mst_ar_valid_o, mst_r_ready_o, ifu_ar_ready_o, lsu_ar_ready_o,
                      ifu_r_valid_o, lsu_r_valid_o}, 64'h0);
        check_output("rst_ifu_r_data", {ifu_r_resp_o, ifu_r_data_o}, 64'h0);
        check_output("rst_lsu_r_data", {lsu_r_resp_o, lsu_r_data_o}, 64'h0);
        check_output("rst_mst_ar_addr", mst_ar_addr_o, 64'h0);
        clear_inputs();
        rst_i = 1'b1;
        tick();
        check_output("post_rst_idle_ar_valid", mst_ar_valid_o, 64'h0);
    endtask

    // Runs one complete read for the expected winner, leaving the loser's request pending.
    task automatic apply_stimulus(input vec_t v);
        if (v.ifu_v) begin
            ifu_ar_valid_i = 1'b1;
            ifu_ar_addr_i  = v.ifu_addr;
        end
        if (v.lsu_v) begin
            lsu_ar_valid_i = 1'b1;
            lsu_ar_addr_i  = v.lsu_addr;
        end
        #1;
        check_output("idle_no_ar_valid", mst_ar_valid_o, 64'h0);
        tick();

        mst_r_valid_i = 1'b1;
        mst_r_data_i  = 32'hBAD0_BAD0;
        ifu_r_ready_i = 1'b1;
        lsu_r_ready_i = 1'b1;
        for (int i = 0; i < v.ar_delay; i++) begin
            #1;
            check_output("addr_stall_ar_valid", mst_ar_valid_o, 64'h1);
            check_output("addr_stall_ar_addr", mst_ar_addr_o, v.exp_addr);
            check_output("addr_stall_ar_ready", {ifu_ar_ready_o, lsu_ar_ready_o}, 64'h0);
            check_output("addr_spurious_r", {ifu_r_valid_o, lsu_r_valid_o, mst_r_ready_o}, 64'h0);
            tick();
        end
        mst_ar_ready_i = 1'b1;
        mst_r_valid_i  = 1'b0;
        #1;
        check_output("addr_ar_valid", mst_ar_valid_o, 64'h1);
        check_output("addr_ar_addr", mst_ar_addr_o, v.exp_addr);
        check_output("addr_ar_ready", {ifu_ar_ready_o, lsu_ar_ready_o},
                     v.exp_grant ? 64'h1 : 64'h2);
        tick();

        mst_ar_ready_i = 1'b0;
        if (v.exp_grant) begin
            lsu_ar_valid_i = 1'b0;
            lsu_r_ready_i  = (v.rdy_delay == 0);
            ifu_r_ready_i  = 1'b1;
        end else begin
            ifu_ar_valid_i = 1'b0;
            ifu_r_ready_i  = (v.rdy_delay == 0);
            lsu_r_ready_i  = 1'b1;
        end
        for (int i = 0; i < v.r_delay; i++) begin
            #1;
            check_output("data_wait_r_valid", {ifu_r_valid_o, lsu_r_valid_o}, 64'h0);
            check_output("data_wait_ar_valid", mst_ar_valid_o, 64'h0);
            tick();
        end
        mst_r_valid_i = 1'b1;
        mst_r_data_i  = v.rdata;
        mst_r_resp_i  = v.rresp;
        for (int i = 0; i < v.rdy_delay; i++) begin
            #1;
            check_output("data_backpressure_r_valid", {ifu_r_valid_o, lsu_r_valid_o},
                         v.exp_grant ? 64'h1 : 64'h2);
            check_output("data_backpressure_r_ready", mst_r_ready_o, 64'h0);
            tick();
        end
        if (v.exp_grant) lsu_r_ready_i = 1'b1;
        else             ifu_r_ready_i = 1'b1;
        #1;
        check_output("data_r_valid", {ifu_r_valid_o, lsu_r_valid_o}, v.exp_grant ? 64'h1 : 64'h2);
        check_output("data_r_ready", mst_r_ready_o, 64'h1);
        if (v.exp_grant) begin
            check_output("lsu_r_data", lsu_r_data_o, v.rdata);
            check_output("lsu_r_resp", lsu_r_resp_o, v.rresp);
        end else begin
            check_output("ifu_r_data", ifu_r_data_o, v.rdata);
            check_output("ifu_r_resp", ifu_r_resp_o, v.rresp);
        end
        tick();

        mst_r_valid_i = 1'b0;
        mst_r_data_i  = '0;
        mst_r_resp_i  = 2'b00;
        ifu_r_ready_i = 1'b0;
        lsu_r_ready_i = 1'b0;
        #1;
        check_output("back_to_idle", {mst_ar_valid_o, ifu_r_valid_o, lsu_r_valid_o}, 64'h0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0,          1'b0, 32'h8000_0000, 32'h0000_0413, RESP_OKAY,   0, 0, 0};
        vecs[1] = '{1'b1, 1'b1, 32'h8000_0004, 1'b1, 32'h8000_1000, 1'b0, 32'h8000_0004, 32'h1111_0001, RESP_OKAY,   0, 0, 0};
        vecs[2] = '{1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          1'b1, 32'h8000_1000, 32'h2222_0002, RESP_OKAY,   0, 0, 0};
        vecs[3] = '{1'b0, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_1004, 1'b0, 32'h8000_0008, 32'h3333_0003, RESP_OKAY,   4, 5, 2};
        vecs[4] = '{1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          1'b1, 32'h8000_1004, 32'h4444_0004, RESP_SLVERR, 1, 1, 0};
        vecs[5] = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF, RESP_DECERR, 0, 2, 1};
        vecs[6] = '{1'b0, 1'b1, 32'h8000_000C, 1'b0, 32'h0,          1'b0, 32'h8000_000C, 32'h5555_0005, RESP_OKAY,   2, 0, 1};

        clear_inputs();
        rst_i = 1'b1;
        #2;

        for (int n = 0; n < 7; n++) begin
            if (vecs[n].do_reset) apply_reset();
            apply_stimulus(vecs[n]);
        end

        // Tie with last=IFU goes to LSU; reset then lands while its read data is on the bus.
        ifu_ar_valid_i = 1'b1;
        ifu_ar_addr_i  = 32'h8000_0010;
        lsu_ar_valid_i = 1'b1;
        lsu_ar_addr_i  = 32'h8000_2000;
        tick();
        mst_ar_ready_i = 1'b1;
        #1;
        check_output("tie_lsu_addr", mst_ar_addr_o, 64'h8000_2000);
        tick();
        mst_ar_ready_i = 1'b0;
        mst_r_valid_i  = 1'b1;
        mst_r_data_i   = 32'h7777_7777;
        mst_r_resp_i   = RESP_OKAY;
        lsu_r_ready_i  = 1'b0;
        #1;
        check_output("pre_rst_lsu_r_valid", lsu_r_valid_o, 64'h1);
        #1;
        rst_i = 1'b0;
        #1;
        check_output("async_rst_r_valid", {ifu_r_valid_o, lsu_r_valid_o, mst_r_ready_o}, 64'h0);
        check_output("async_rst_r_data", lsu_r_data_o, 64'h0);
        check_output("async_rst_ar_valid", mst_ar_valid_o, 64'h0);
        tick();
        tick();
        rst_i = 1'b1;
        #1;
        check_output("post_rst_idle_no_r", {ifu_r_valid_o, lsu_r_valid_o, mst_ar_valid_o}, 64'h0);
        tick();
        mst_ar_ready_i = 1'b1;
        #1;
        check_output("post_rst_tie_ifu_addr", mst_ar_addr_o, 64'h8000_0010);
        check_output("post_rst_tie_ar_ready", {ifu_ar_ready_o, lsu_ar_ready_o}, 64'h2);
        check_output("post_rst_addr_no_r", {ifu_r_valid_o, lsu_r_valid_o, mst_r_ready_o}, 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
